// File: rtl/ftdi_tx.sv
// FT245 synchronous-FIFO write path: buffers bytes and strobes them onto the FTDI bus,
// retrying any byte the FTDI rejects (txe_n high on a strobe edge).
module ftdi_tx #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_60,
    input  logic                  rst_n,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DEPTH_LOG2:0]   level,
    input  logic                  bus_grant,
    input  logic                  txe_n,
    output logic                  wr_n,
    output logic [7:0]            data_out,
    output logic                  data_oe
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        TURN,
        WRITE
    } state_t;

    state_t                state, state_nx;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr, rd_ptr_nx;
    logic [DEPTH_LOG2:0]   level_after_pop, level_nx;
    logic                  push, pop, go, go_after_pop;
    logic [7:0]            head_nx;

    assign in_ready        = (level != FULL);
    assign push            = in_valid && in_ready;
    assign pop             = !wr_n && !txe_n;
    assign go              = (level != '0) && bus_grant && !txe_n;
    assign level_after_pop = level - (DEPTH_LOG2 + 1)'(pop);
    assign go_after_pop    = (level_after_pop != '0) && bus_grant && !txe_n;
    assign level_nx        = level_after_pop + (DEPTH_LOG2 + 1)'(push);
    assign rd_ptr_nx       = rd_ptr + DEPTH_LOG2'(pop);

    // Pushing into an (effectively) empty FIFO bypasses the array so data_out is never stale.
    always_comb begin
        head_nx = mem[rd_ptr_nx];
        if (push && (wr_ptr == rd_ptr_nx)) begin
            head_nx = in_data;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = TURN;
            TURN:    state_nx = go ? WRITE : IDLE;
            WRITE:   if (!go_after_pop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_60 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wr_n     <= 1'b1;
            data_oe  <= 1'b0;
            data_out <= '0;
            level    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            state    <= state_nx;
            wr_n     <= (state_nx != WRITE);
            data_oe  <= (state_nx != IDLE);
            data_out <= head_nx;
            level    <= level_nx;
            rd_ptr   <= rd_ptr_nx;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_60) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_ftdi_tx.sv
// Bench for ftdi_tx: an FTDI receiver model plus a byte-queue scoreboard,
// a vector table for the basic burst, directed corner cases and random traffic.
module tb_ftdi_tx;

    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int unsigned DEPTH      = 1 << DEPTH_LOG2;

    logic                clk_60 = 1'b0;
    logic                rst_n;
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DEPTH_LOG2:0] level;
    logic                bus_grant;
    logic                txe_n;
    logic                wr_n;
    logic [7:0]          data_out;
    logic                data_oe;

    ftdi_tx #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk_60    (clk_60),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .level     (level),
        .bus_grant (bus_grant),
        .txe_n     (txe_n),
        .wr_n      (wr_n),
        .data_out  (data_out),
        .data_oe   (data_oe)
    );

    always #8 clk_60 = ~clk_60;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] model_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    bit         last_acc;
    bit         last_push;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       gr;
        logic       tx;
        logic       e_wr;
        logic       e_oe;
        logic [4:0] e_lvl;
        logic       e_rdy;
        logic       chk_d;
        logic [7:0] e_d;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: FTDI model and scoreboard act on pre-edge values, then post-edge checks.
    // Must be entered just after a falling edge; returns just after the next falling edge.
    task automatic tick();
        int unsigned sz;
        bit acc, psh, go, stay, was_write, was_turn, was_idle;
        sz        = model_q.size();
        acc       = (wr_n === 1'b0) && (txe_n === 1'b0);
        psh       = (in_valid === 1'b1) && (sz < DEPTH);
        go        = (sz != 0) && bus_grant && !txe_n;
        stay      = ((acc ? sz - 1 : sz) != 0) && bus_grant && !txe_n;
        was_write = (wr_n === 1'b0);
        was_turn  = (wr_n === 1'b1) && (data_oe === 1'b1);
        was_idle  = (wr_n === 1'b1) && (data_oe === 1'b0);
        if (acc) begin
            check("accept_nonempty", 32'(sz != 0), 32'd1);
            if (sz != 0) begin
                check("accept_data", 32'(data_out), 32'(model_q[0]));
                rx_q.push_back(data_out);
                void'(model_q.pop_front());
            end
        end
        if (psh) model_q.push_back(in_data);
        last_acc  = acc;
        last_push = psh;
        @(posedge clk_60);
        @(negedge clk_60);
        check("level", 32'(level), 32'(model_q.size()));
        check("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
        if (model_q.size() != 0) check("head_data", 32'(data_out), 32'(model_q[0]));
        if (was_write) begin
            check("write_wr_n", 32'(wr_n), 32'(!stay));
            check("write_oe", 32'(data_oe), 32'(stay));
        end else if (was_turn) begin
            check("turn_wr_n", 32'(wr_n), 32'(!go));
            check("turn_oe", 32'(data_oe), 32'(go));
        end else if (was_idle) begin
            check("idle_wr_n", 32'(wr_n), 32'd1);
            check("idle_oe", 32'(data_oe), 32'(go));
        end
    endtask

    task automatic preload(input int n, input logic [7:0] base);
        bus_grant = 1'b0;
        txe_n     = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_wr_low(input string name, input int bound);
        for (int i = 0; i < bound && wr_n !== 1'b0; i++) tick();
        check(name, 32'(wr_n), 32'd0);
    endtask

    task automatic drain(input string name);
        in_valid  = 1'b0;
        bus_grant = 1'b1;
        txe_n     = 1'b0;
        for (int i = 0; i < 64 && (model_q.size() != 0 || wr_n !== 1'b1); i++) tick();
        check(name, 32'(level), 32'd0);
    endtask

    task automatic check_rx(input string name);
        check(name, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check(name, 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        bus_grant = 1'b0;
        txe_n     = 1'b1;
        repeat (3) @(negedge clk_60);
        check("rst_wr_n", 32'(wr_n), 32'd1);
        check("rst_oe", 32'(data_oe), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_data", 32'(data_out), 32'd0);
        rst_n = 1'b1;

        // Burst 0x01..0x05 from empty: one TURN cycle, then five strobes.
        vt[0] = '{1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 8'h01};
        vt[1] = '{1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 8'h01};
        vt[2] = '{1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 8'h01};
        vt[3] = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 8'h02};
        vt[4] = '{1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1, 8'h03};
        vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 1'b1, 1'b1, 8'h04};
        vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 8'h05};
        vt[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00};
        vt[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00};
        rx_q.delete();
        for (int i = 0; i < 9; i++) begin
            in_valid  = vt[i].iv;
            in_data   = vt[i].id;
            bus_grant = vt[i].gr;
            txe_n     = vt[i].tx;
            tick();
            check("vec_wr_n", 32'(wr_n), 32'(vt[i].e_wr));
            check("vec_oe", 32'(data_oe), 32'(vt[i].e_oe));
            check("vec_level", 32'(level), 32'(vt[i].e_lvl));
            check("vec_in_ready", 32'(in_ready), 32'(vt[i].e_rdy));
            if (vt[i].chk_d) check("vec_data", 32'(data_out), 32'(vt[i].e_d));
        end
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx("vec_rx");

        // Backpressure: reject 0x03, hold txe_n high 4 cycles, then resend after TURN.
        rx_q.delete();
        preload(5, 8'h01);
        bus_grant = 1'b1;
        for (int i = 0; i < 12 && !(wr_n === 1'b0 && data_out === 8'h03); i++) tick();
        check("bp_reach_03", 32'(data_out), 32'h03);
        txe_n = 1'b1;
        tick();
        check("bp_reject_wr_n", 32'(wr_n), 32'd1);
        check("bp_reject_oe", 32'(data_oe), 32'd0);
        check("bp_level", 32'(level), 32'd3);
        repeat (3) begin
            tick();
            check("bp_hold_wr_n", 32'(wr_n), 32'd1);
        end
        txe_n = 1'b0;
        tick();
        check("bp_turn_oe", 32'(data_oe), 32'd1);
        check("bp_turn_wr_n", 32'(wr_n), 32'd1);
        tick();
        check("bp_resend_wr_n", 32'(wr_n), 32'd0);
        check("bp_resend_data", 32'(data_out), 32'h03);
        drain("bp_drain");
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        check_rx("bp_rx");

        // Full: 17 pushes with txe_n high, the 17th blocked until a pop.
        rx_q.delete();
        exp_q.delete();
        bus_grant = 1'b1;
        txe_n     = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(i);
            tick();
            if (i < 16) exp_q.push_back(in_data);
        end
        check("full_level", 32'(level), 32'(DEPTH));
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_blocked", 32'(last_push), 32'd0);
        exp_q.push_back(8'h50);
        txe_n = 1'b0;
        for (int i = 0; i < 20 && !last_push; i++) tick();
        check("full_late_push", 32'(last_push), 32'd1);
        in_valid = 1'b0;
        drain("full_drain");
        check_rx("full_rx");

        // Grant loss mid-burst, then regrant.
        rx_q.delete();
        preload(6, 8'h60);
        bus_grant = 1'b1;
        wait_wr_low("gl_start", 8);
        tick();
        bus_grant = 1'b0;
        tick();
        check("gl_counted", 32'(last_acc), 32'd1);
        check("gl_wr_n", 32'(wr_n), 32'd1);
        check("gl_oe", 32'(data_oe), 32'd0);
        repeat (3) begin
            tick();
            check("gl_hold_wr_n", 32'(wr_n), 32'd1);
        end
        bus_grant = 1'b1;
        tick();
        check("gl_turn_oe", 32'(data_oe), 32'd1);
        check("gl_turn_wr_n", 32'(wr_n), 32'd1);
        tick();
        check("gl_resume_wr_n", 32'(wr_n), 32'd0);
        drain("gl_drain");
        exp_q = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
        check_rx("gl_rx");

        // Push and pop on the same edge at level 8.
        rx_q.delete();
        preload(8, 8'h70);
        bus_grant = 1'b1;
        wait_wr_low("cc_start", 8);
        check("cc_level_before", 32'(level), 32'd8);
        in_valid = 1'b1;
        in_data  = 8'h7F;
        tick();
        check("cc_both", 32'(last_acc && last_push), 32'd1);
        check("cc_level", 32'(level), 32'd8);
        in_valid = 1'b0;
        drain("cc_drain");
        exp_q = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h7F};
        check_rx("cc_rx");

        // Reset mid-burst: immediate clear, nothing stale sent afterwards.
        preload(6, 8'h90);
        bus_grant = 1'b1;
        wait_wr_low("rm_start", 8);
        tick();
        rst_n = 1'b0;
        #2;
        check("rm_wr_n", 32'(wr_n), 32'd1);
        check("rm_oe", 32'(data_oe), 32'd0);
        check("rm_level", 32'(level), 32'd0);
        check("rm_in_ready", 32'(in_ready), 32'd1);
        check("rm_data", 32'(data_out), 32'd0);
        model_q.delete();
        @(negedge clk_60);
        @(negedge clk_60);
        rst_n = 1'b1;
        repeat (10) begin
            tick();
            check("rm_no_stale", 32'(wr_n), 32'd1);
        end

        // Random traffic against the scoreboard.
        rx_q.delete();
        for (int i = 0; i < 3000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            if ($urandom_range(0, 15) == 0) bus_grant = ~bus_grant;
            txe_n     = ($urandom_range(0, 3) == 0);
            tick();
        end
        drain("rand_drain");
        check("rand_model_empty", 32'(model_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
